// File: rtl/vliw_spi_flash_rd_if.sv
// Bus bundle between the flash read sequencer, its consumer and the SPI byte engine.
interface vliw_spi_flash_rd_if;
  logic        req;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        CS_n;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  spi_din;
  logic        spi_start;
  logic [7:0]  spi_dout;
  logic        spi_busy;

  modport master (
    output req, addr, len, rd_ready, spi_dout, spi_busy,
    input  busy, done, CS_n, rd_data, rd_valid, spi_din, spi_start
  );

  modport slave (
    input  req, addr, len, rd_ready, spi_dout, spi_busy,
    output busy, done, CS_n, rd_data, rd_valid, spi_din, spi_start
  );
endinterface

// File: rtl/vliw_spi_flash_rd.sv
// SPI flash read sequencer: owns CS_n, sends opcode + 24-bit address through
// the byte engine, then clocks in N data bytes onto a valid/ready output.
module vliw_spi_flash_rd #(
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input logic               clk,
  input logic               rst,
  vliw_spi_flash_rd_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, WAIT_HI, WAIT_LO, PRESENT, HOLD, DONE
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  phase, phase_nxt;
  logic [8:0]  remaining, rem_nxt;
  logic [23:0] addr_q, addr_nxt;

  logic        cs_n_q, cs_n_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic [7:0]  rd_data_q, rd_data_nxt;
  logic        rd_valid_q, rd_valid_nxt;
  logic [7:0]  spi_din_q, spi_din_nxt;
  logic        spi_start_q, spi_start_nxt;

  // Phase saturates at 4; every byte from there on is a data byte.
  logic data_phase;
  assign data_phase = phase[2];

  assign bus.CS_n      = cs_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.spi_din   = spi_din_q;
  assign bus.spi_start = spi_start_q;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      phase       <= '0;
      remaining   <= '0;
      addr_q      <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      spi_din_q   <= '0;
      spi_start_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      phase       <= phase_nxt;
      remaining   <= rem_nxt;
      addr_q      <= addr_nxt;
      cs_n_q      <= cs_n_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      rd_data_q   <= rd_data_nxt;
      rd_valid_q  <= rd_valid_nxt;
      spi_din_q   <= spi_din_nxt;
      spi_start_q <= spi_start_nxt;
    end
  end

  // Next-state sequencing of one read transaction.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req) state_nxt = SETUP;
      SETUP:   if (cnt == SETUP_LAST) state_nxt = XFER;
      XFER:    state_nxt = WAIT_HI;
      WAIT_HI: if (bus.spi_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!bus.spi_busy) state_nxt = data_phase ? PRESENT : XFER;
      PRESENT: if (rd_valid_q && bus.rd_ready)
                 state_nxt = (remaining == 9'd1) ? HOLD : XFER;
      HOLD:    if (cnt == HOLD_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of datapath and outputs; outputs are looked up from state_nxt
  // so that they are registered yet line up with the state they belong to.
  always_comb begin
    cnt_nxt      = '0;
    phase_nxt    = phase;
    rem_nxt      = remaining;
    addr_nxt     = addr_q;
    cs_n_nxt     = cs_n_q;
    busy_nxt     = busy_q;
    rd_data_nxt  = rd_data_q;
    rd_valid_nxt = rd_valid_q;
    spi_din_nxt  = spi_din_q;

    if ((state == SETUP || state == HOLD) && state_nxt == state)
      cnt_nxt = cnt + 8'd1;

    unique case (state)
      IDLE: begin
        if (bus.req) begin
          addr_nxt  = bus.addr;
          rem_nxt   = (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
          phase_nxt = '0;
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.spi_busy) begin
          if (data_phase) begin
            rd_data_nxt  = bus.spi_dout;
            rd_valid_nxt = 1'b1;
          end else begin
            phase_nxt = phase + 3'd1;
          end
        end
      end
      PRESENT: begin
        if (rd_valid_q && bus.rd_ready) begin
          rd_valid_nxt = 1'b0;
          rem_nxt      = remaining - 9'd1;
        end
      end
      HOLD:    if (cnt == HOLD_LAST) cs_n_nxt = 1'b1;
      DONE:    busy_nxt = 1'b0;
      default: ;
    endcase

    done_nxt      = (state_nxt == DONE);
    spi_start_nxt = (state_nxt == XFER);

    if (state_nxt == XFER) begin
      unique case (phase_nxt)
        3'd0:    spi_din_nxt = READ_CMD;
        3'd1:    spi_din_nxt = addr_nxt[23:16];
        3'd2:    spi_din_nxt = addr_nxt[15:8];
        3'd3:    spi_din_nxt = addr_nxt[7:0];
        default: spi_din_nxt = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_vliw_spi_flash_rd.sv
// Scoreboard bench for vliw_spi_flash_rd with a behavioural SPI byte engine.
module tb_vliw_spi_flash_rd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vliw_spi_flash_rd_if bus ();

  vliw_spi_flash_rd #(
    .READ_CMD (8'h03),
    .CS_SETUP (2),
    .CS_HOLD  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_din[$];
  logic [7:0] exp_rd[$];

  int cyc = 0;
  int n_start, n_hs, n_done, cs_viol;
  int t_fall, t_start, t_acc, t_rise;
  logic cs_prev = 1'b1;

  int et   = 0;
  int eidx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] eng_data(input int j);
    return 8'(32'hA5 + j * 59);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts;
    n_start = 0;
    n_hs    = 0;
    n_done  = 0;
    cs_viol = 0;
  endtask

  task automatic push_txn(input logic [23:0] a, input logic [7:0] l);
    int n;
    n = (l == 8'd0) ? 256 : int'(l);
    exp_din.push_back(8'h03);
    exp_din.push_back(a[23:16]);
    exp_din.push_back(a[15:8]);
    exp_din.push_back(a[7:0]);
    for (int j = 0; j < n; j++) begin
      exp_din.push_back(8'h00);
      exp_rd.push_back(eng_data(j));
    end
  endtask

  task automatic start_txn(input logic [23:0] a, input logic [7:0] l);
    push_txn(a, l);
    clear_counts();
    bus.addr = a;
    bus.len  = l;
    bus.req  = 1'b1;
    tick();
    bus.req  = 1'b0;
  endtask

  task automatic finish_txn(input string nm, input int nbytes, input int maxc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, "_done_seen"}, 32'(ok), 1);
    check({nm, "_starts"}, n_start, nbytes + 4);
    check({nm, "_handshakes"}, n_hs, nbytes);
    check({nm, "_cs_high_with_done"}, 32'(bus.CS_n), 1);
    tick();
    check({nm, "_done_pulse"}, 32'(bus.done), 0);
    check({nm, "_busy_after"}, 32'(bus.busy), 0);
    check({nm, "_done_count"}, n_done, 1);
    check({nm, "_cs_low_whole_txn"}, cs_viol, 0);
    check({nm, "_din_queue_empty"}, exp_din.size(), 0);
    check({nm, "_rd_queue_empty"}, exp_rd.size(), 0);
    check({nm, "_cs_setup"}, t_start - t_fall, 2);
    check({nm, "_cs_hold"}, t_rise - t_acc, 2);
  endtask

  // Behavioural byte engine: busy rises 2 cycles after start, falls 6 later
  // with the received byte; data bytes follow eng_data() per transaction.
  always @(negedge clk) begin
    if (bus.CS_n) eidx = 0;
    if (et > 0) begin
      et++;
      if (et == 3) bus.spi_busy = 1'b1;
      if (et == 9) begin
        bus.spi_busy = 1'b0;
        bus.spi_dout = (eidx >= 5) ? eng_data(eidx - 5) : 8'hFF;
        et = 0;
      end
    end
    if (bus.spi_start) begin
      et = 1;
      eidx++;
    end
  end

  always @(posedge clk) cyc++;

  // Monitor: scoreboard pops for transmitted bytes and delivered data, plus CS timing.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.spi_start) begin
        n_start++;
        if (n_start == 1) t_start = cyc;
        check("din_expected", 32'(exp_din.size() != 0), 1);
        if (exp_din.size() != 0) check("spi_din", 32'(bus.spi_din), 32'(exp_din.pop_front()));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        n_hs++;
        t_acc = cyc + 1;
        check("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
      end
      if (bus.done) n_done++;
      if (bus.busy && !bus.done && bus.CS_n) cs_viol++;
    end
    if (cs_prev && !bus.CS_n) t_fall = cyc;
    if (!cs_prev && bus.CS_n) t_rise = cyc;
    cs_prev = bus.CS_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok;
    logic [7:0] held;
    int         s0, bad;

    rst          = 1'b1;
    bus.req      = 1'b0;
    bus.addr     = '0;
    bus.len      = '0;
    bus.rd_ready = 1'b1;
    bus.spi_busy = 1'b0;
    bus.spi_dout = '0;
    clear_counts();
    repeat (3) tick();
    check("rst_cs_n", 32'(bus.CS_n), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    check("rst_spi_start", 32'(bus.spi_start), 0);
    check("rst_spi_din", 32'(bus.spi_din), 0);
    rst = 1'b0;
    tick();

    // Single byte read: 03 12 34 56 00, data A5.
    start_txn(24'h123456, 8'd1);
    check("t1_busy_on_accept", 32'(bus.busy), 1);
    check("t1_cs_on_accept", 32'(bus.CS_n), 0);
    finish_txn("t1", 1, 300);

    // len=0 means 256 bytes.
    start_txn(24'h00A0C0, 8'd0);
    finish_txn("t2", 256, 5000);

    // Backpressure on byte 2.
    bus.rd_ready = 1'b0;
    start_txn(24'h000100, 8'd3);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rd_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("t3_byte1_valid", 32'(ok), 1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rd_valid) begin ok = 1'b1; break; end
      tick();
    end
    check("t3_byte2_valid", 32'(ok), 1);
    held = bus.rd_data;
    s0   = n_start;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.rd_valid || bus.rd_data !== held) bad++;
    end
    check("t3_stable_under_backpressure", bad, 0);
    check("t3_no_start_while_stalled", n_start, s0);
    bus.rd_ready = 1'b1;
    finish_txn("t3", 3, 300);

    // Reset during WAIT_LO of the third (address) byte.
    start_txn(24'hFEDCBA, 8'd2);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_start >= 3 && bus.spi_busy) begin ok = 1'b1; break; end
      tick();
    end
    check("t4_reached_byte3", 32'(ok), 1);
    rst = 1'b1;
    tick();
    check("t4_cs_n_after_rst", 32'(bus.CS_n), 1);
    check("t4_busy_after_rst", 32'(bus.busy), 0);
    check("t4_rd_valid_after_rst", 32'(bus.rd_valid), 0);
    check("t4_spi_start_after_rst", 32'(bus.spi_start), 0);
    rst = 1'b0;
    exp_din.delete();
    exp_rd.delete();
    for (int i = 0; i < 20; i++) begin
      if (et == 0 && !bus.spi_busy) break;
      tick();
    end
    tick();
    start_txn(24'h3C5A7E, 8'd2);
    finish_txn("t4_after", 2, 300);

    // req held high across DONE: the next transaction latches IDLE-cycle values.
    push_txn(24'hABCDEF, 8'd1);
    clear_counts();
    bus.addr = 24'hABCDEF;
    bus.len  = 8'd1;
    bus.req  = 1'b1;
    tick();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.done) begin ok = 1'b1; break; end
    end
    check("t5a_done_seen", 32'(ok), 1);
    check("t5a_starts", n_start, 5);
    check("t5a_handshakes", n_hs, 1);
    bus.addr = 24'h00FF10;
    bus.len  = 8'd2;
    push_txn(24'h00FF10, 8'd2);
    tick();
    check("t5_idle_busy", 32'(bus.busy), 0);
    check("t5_idle_cs_n", 32'(bus.CS_n), 1);
    clear_counts();
    tick();
    bus.req = 1'b0;
    check("t5_accept_busy", 32'(bus.busy), 1);
    check("t5_accept_cs_n", 32'(bus.CS_n), 0);
    finish_txn("t5b", 2, 300);

    // CS setup/hold timing on a plain multi-byte read.
    start_txn(24'h800001, 8'd4);
    finish_txn("t6", 4, 400);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
